// File: rtl/lcd_char_driver_if.sv
// Frame input, update request and HD44780 4-bit bus
// of the LCD character driver.
interface lcd_char_driver_if;
  logic [255:0] strdata;
  logic         update;
  logic         busy;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [3:0]   lcd_dat;

  modport master (
    output strdata, update,
    input  busy, lcd_e, lcd_rs,
    input  lcd_rw, lcd_dat
  );

  modport slave (
    input  strdata, update,
    output busy, lcd_e, lcd_rs,
    output lcd_rw, lcd_dat
  );
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780 2x16 driver: init, then writes a 32-char frame.
// Optional macro LCD_AUTOREFRESH_EN: rewrite when input differs.
module lcd_char_driver #(
  parameter int PWRUP_CYC   = 750000,
  parameter int INIT_CYC    = 205000,
  parameter int E_CYC       = 12,
  parameter int NIB_GAP_CYC = 50,
  parameter int CMD_CYC     = 2000,
  parameter int CLR_CYC     = 82000
) (
  input  logic clk,
  input  logic rst,
  lcd_char_driver_if.slave bus
);

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT1, S_INIT2, S_INIT3,
    S_INIT4, S_CFG,   S_SNAP,  S_ADDR1,
    S_LINE1, S_ADDR2, S_LINE2, S_IDLE
  } st_t;

  typedef enum logic [1:0] {
    P_SET, P_EHI, P_WAIT
  } ph_t;

  localparam logic [19:0] C_PWR  = 20'(PWRUP_CYC - 1);
  localparam logic [19:0] C_INIT = 20'(INIT_CYC - 1);
  localparam logic [19:0] C_E    = 20'(E_CYC - 1);
  localparam logic [19:0] C_GAP  = 20'(NIB_GAP_CYC - 1);
  localparam logic [19:0] C_CMD  = 20'(CMD_CYC - 1);
  localparam logic [19:0] C_CLR  = 20'(CLR_CYC - 1);

  st_t          st, st_n;
  ph_t          ph, ph_n;
  logic         lo, lo_n;
  logic [4:0]   idx, idx_n;
  logic [19:0]  cnt, cnt_n;
  logic         pend, pend_n;
  logic         e_q, e_n;
  logic         rs_q, rs_n;
  logic [3:0]   dat_q, dat_n;
  logic [255:0] frame;
  logic [7:0]   cur_b;
  logic [19:0]  wlen;
  logic         busy;
  logic         go;

  function automatic logic [7:0] byte_f(
    input st_t          s,
    input logic [4:0]   i,
    input logic [255:0] f
  );
    logic [7:0] pos;
    pos = {~i, 3'b111};
    case (s)
      S_CFG: begin
        case (i[1:0])
          2'd0:    byte_f = 8'h28;
          2'd1:    byte_f = 8'h06;
          2'd2:    byte_f = 8'h0C;
          default: byte_f = 8'h01;
        endcase
      end
      S_ADDR1: byte_f = 8'h80;
      S_ADDR2: byte_f = 8'hC0;
      S_LINE1,
      S_LINE2: byte_f = f[pos -: 8];
      default: byte_f = 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] nib_f(
    input st_t          s,
    input logic         l,
    input logic [4:0]   i,
    input logic [255:0] f
  );
    logic [7:0] b;
    logic       r;
    b = byte_f(s, i, f);
    r = (s == S_LINE1) || (s == S_LINE2);
    case (s)
      S_INIT1,
      S_INIT2,
      S_INIT3: nib_f = 5'h03;
      S_INIT4: nib_f = 5'h02;
      default: nib_f = {r, l ? b[3:0] : b[7:4]};
    endcase
  endfunction

  assign busy = (st != S_IDLE);

`ifdef LCD_AUTOREFRESH_EN
  assign go = bus.update | (bus.strdata != frame);
`else
  assign go = bus.update;
`endif

  always_comb begin
    st_n  = st;
    ph_n  = ph;
    lo_n  = lo;
    idx_n = idx;
    cnt_n = cnt;
    cur_b = byte_f(st, idx, frame);
    wlen  = C_CMD;
    unique case (st)
      S_INIT1: wlen = C_INIT;
      S_INIT2,
      S_INIT3,
      S_INIT4: wlen = C_CMD;
      default: begin
        if (!lo)               wlen = C_GAP;
        else if (cur_b == 8'h01) wlen = C_CLR;
        else                   wlen = C_CMD;
      end
    endcase
    unique case (st)
      S_PWRUP: begin
        if (cnt != 20'd0) cnt_n = cnt - 20'd1;
        else begin
          st_n = S_INIT1;
          ph_n = P_SET;
        end
      end
      S_SNAP: begin
        st_n = S_ADDR1;
        ph_n = P_SET;
        lo_n = 1'b0;
      end
      S_IDLE: begin
        if (go) begin
          st_n = S_SNAP;
          ph_n = P_WAIT;
        end
      end
      default: begin
        unique case (ph)
          P_SET: begin
            ph_n  = P_EHI;
            cnt_n = C_E;
          end
          P_EHI: begin
            if (cnt != 20'd0) cnt_n = cnt - 20'd1;
            else begin
              ph_n  = P_WAIT;
              cnt_n = wlen;
            end
          end
          default: begin
            if (cnt != 20'd0) cnt_n = cnt - 20'd1;
            else begin
              ph_n = P_SET;
              case (st)
                S_INIT1: st_n = S_INIT2;
                S_INIT2: st_n = S_INIT3;
                S_INIT3: st_n = S_INIT4;
                S_INIT4: begin
                  st_n  = S_CFG;
                  idx_n = 5'd0;
                  lo_n  = 1'b0;
                end
                default: begin
                  if (!lo) lo_n = 1'b1;
                  else begin
                    lo_n = 1'b0;
                    case (st)
                      S_CFG: begin
                        if (idx == 5'd3) begin
                          st_n = S_SNAP;
                          ph_n = P_WAIT;
                        end else idx_n = idx + 5'd1;
                      end
                      S_ADDR1: begin
                        st_n  = S_LINE1;
                        idx_n = 5'd0;
                      end
                      S_LINE1: begin
                        if (idx == 5'd15) st_n = S_ADDR2;
                        else idx_n = idx + 5'd1;
                      end
                      S_ADDR2: begin
                        st_n  = S_LINE2;
                        idx_n = 5'd16;
                      end
                      default: begin
                        // a request seen this cycle must not be lost
                        if (idx == 5'd31) begin
                          st_n = (pend | bus.update) ? S_SNAP : S_IDLE;
                          ph_n = P_WAIT;
                        end else idx_n = idx + 5'd1;
                      end
                    endcase
                  end
                end
              endcase
            end
          end
        endcase
      end
    endcase
    pend_n = (pend & ~(st_n == S_SNAP && st != S_SNAP))
           | (bus.update & busy);
    e_n = (ph_n == P_EHI);
    // bus values change only when a nibble's setup cycle begins
    if (ph_n == P_SET) {rs_n, dat_n} = nib_f(st_n, lo_n, idx_n, frame);
    else               {rs_n, dat_n} = {rs_q, dat_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_PWRUP;
      ph    <= P_WAIT;
      lo    <= 1'b0;
      idx   <= 5'd0;
      cnt   <= C_PWR;
      pend  <= 1'b0;
      e_q   <= 1'b0;
      rs_q  <= 1'b0;
      dat_q <= 4'd0;
    end else begin
      st    <= st_n;
      ph    <= ph_n;
      lo    <= lo_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      e_q   <= e_n;
      rs_q  <= rs_n;
      dat_q <= dat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (st == S_SNAP) frame <= bus.strdata;
  end

  assign bus.busy    = busy;
  assign bus.lcd_e   = e_q;
  assign bus.lcd_rs  = rs_q;
  assign bus.lcd_rw  = 1'b0;
  assign bus.lcd_dat = dat_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: nibble scoreboard on lcd_e rises
// plus strobe timing checks, with short timing parameters.
module tb_lcd_char_driver;

  typedef struct packed {
    logic       rs;
    logic [3:0] d;
    logic [5:0] gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   pulses = 0;
  exp_t q[$];

  lcd_char_driver_if bus();

  lcd_char_driver #(
    .PWRUP_CYC  (100),
    .INIT_CYC   (40),
    .E_CYC      (2),
    .NIB_GAP_CYC(2),
    .CMD_CYC    (5),
    .CLR_CYC    (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] d,
                          input int gap);
    exp_t e;
    e.rs  = rs;
    e.d   = d;
    e.gap = 6'(gap);
    q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b,
                           input int gap);
    push_nib(rs, b[7:4], gap);
    push_nib(rs, b[3:0], 0);
  endtask

  task automatic push_pass(input logic [255:0] s, input int gap);
    push_byte(1'b0, 8'h80, gap);
    for (int i = 0; i < 16; i++) push_byte(1'b1, s[255-8*i -: 8], 0);
    push_byte(1'b0, 8'hC0, 0);
    for (int i = 16; i < 32; i++) push_byte(1'b1, s[255-8*i -: 8], 0);
  endtask

  task automatic push_init(input logic [255:0] s);
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h2, 0);
    push_byte(1'b0, 8'h28, 0);
    push_byte(1'b0, 8'h06, 0);
    push_byte(1'b0, 8'h0C, 0);
    push_byte(1'b0, 8'h01, 0);
    push_pass(s, 20);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (bus.busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse_update();
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  // strobe monitor and scoreboard consumer
  logic       pe = 1'b0;
  logic       prs = 1'b0;
  logic [3:0] pdat = 4'd0;
  logic       hold_chk = 1'b0;
  logic [4:0] hold_v = 5'd0;
  int         hi_len = 0;
  int         lo_len = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pe = 1'b0;
      hold_chk = 1'b0;
      hi_len = 0;
      lo_len = 0;
    end else begin
      if (hold_chk) begin
        chk("hold", 32'({bus.lcd_rs, bus.lcd_dat}), 32'(hold_v));
        hold_chk = 1'b0;
      end
      if (bus.lcd_e && !pe) begin
        pulses++;
        chk("setup", 32'({bus.lcd_rs, bus.lcd_dat}),
            32'({prs, pdat}));
        chk("rw", 32'(bus.lcd_rw), 32'd0);
        nvec++;
        assert (q.size() != 0) else begin
          nerr++;
          $error("FAIL extra_pulse: got pulse %0d want none", pulses);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("nibble", 32'({bus.lcd_rs, bus.lcd_dat}),
              32'({e.rs, e.d}));
          if (e.gap != 0) begin
            nvec++;
            assert (lo_len >= int'(e.gap)) else begin
              nerr++;
              $error("FAIL clr_gap: got %0d want >=%0d",
                     lo_len, e.gap);
            end
          end
        end
        hi_len = 1;
      end else if (bus.lcd_e) begin
        hi_len++;
      end else if (pe) begin
        chk("e_width", 32'(hi_len), 32'd2);
        hold_chk = 1'b1;
        hold_v = {prs, pdat};
        lo_len = 1;
      end else begin
        lo_len++;
      end
      pe = bus.lcd_e;
      prs = bus.lcd_rs;
      pdat = bus.lcd_dat;
    end
  end

  logic [255:0] s1, s2, s3, s4;
  int base;

  initial begin
    s1 = "R00:000 00000000FD00|E00|M00|W00";
    s2 = "HELLO WORLD 1234abcdefghijklmnop";
    s3 = "Line one text okSecond line here";
    s4 = "~!@#$%^&*()_+-=00123456789ABCDEF";
    bus.strdata = s1;
    bus.update = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_e", 32'(bus.lcd_e), 32'd0);
    chk("rst_rs", 32'(bus.lcd_rs), 32'd0);
    chk("rst_dat", 32'(bus.lcd_dat), 32'd0);
    chk("rst_rw", 32'(bus.lcd_rw), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);

    // power-up init and first pass
    base = pulses;
    push_init(s1);
    rst = 1'b0;
    wait_idle("init", 4000);
    chk("init_pulses", 32'(pulses - base), 32'd80);
    chk("init_q", 32'(q.size()), 32'd0);

    // update from IDLE: pass only, no init
    bus.strdata = s2;
    push_pass(s2, 0);
    base = pulses;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    pulse_update();
    chk("upd_busy", 32'(bus.busy), 32'd1);
    wait_idle("upd", 3000);
    chk("upd_pulses", 32'(pulses - base), 32'd68);
    chk("upd_q", 32'(q.size()), 32'd0);

    // collapsed updates during a pass, input changed mid-pass
    bus.strdata = s3;
    push_pass(s3, 0);
    push_pass(s4, 0);
    base = pulses;
    pulse_update();
    repeat (60) @(negedge clk);
    bus.strdata = s4;
    for (int k = 0; k < 3; k++) begin
      pulse_update();
      repeat (10) @(negedge clk);
    end
    chk("pend_busy", 32'(bus.busy), 32'd1);
    wait_idle("pend", 4000);
    chk("pend_pulses", 32'(pulses - base), 32'd136);
    repeat (50) @(negedge clk);
    chk("pend_stay", 32'(bus.busy), 32'd0);
    chk("pend_nomore", 32'(pulses - base), 32'd136);

    // reset while lcd_e is high during line 1
    bus.strdata = s1;
    push_pass(s1, 0);
    base = pulses;
    pulse_update();
    begin
      int n = 0;
      while (!((pulses - base) >= 10 && bus.lcd_e) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach", 32'(bus.lcd_e), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_e", 32'(bus.lcd_e), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    q.delete();
    push_init(s1);
    @(negedge clk);
    rst = 1'b0;
    base = pulses;
    repeat (100) @(negedge clk);
    chk("mid_quiet", 32'(pulses - base), 32'd0);
    wait_idle("reinit", 4000);
    chk("reinit_pulses", 32'(pulses - base), 32'd80);
    chk("reinit_q", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Downstream consumer of the status-string formatter. Takes a 256-bit, 32-character ASCII frame and drives an HD44780-compatible 2x16 character LCD over the 4-bit, write-only bus.
- Performs power-up initialisation, then writes line 1 (chars 0–15) and line 2 (chars 16–31).
- Re-writes the frame on an update pulse without re-initialising the LCD.

Parameters:
- PWRUP_CYC, 750000: idle cycles after reset before the first nibble (15 ms at 50 MHz).
- INIT_CYC, 205000: wait after the first 0x3 init nibble (4.1 ms).
- E_CYC, 12: cycles lcd_e is held high per nibble.
- NIB_GAP_CYC, 50: cycles between the high and low nibble of one byte.
- CMD_CYC, 2000: wait after each byte and after init nibbles 2–4 (40 us).
- CLR_CYC, 82000: wait after the clear command 0x01 (1.64 ms).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- strdata, input, 256: frame; char i = strdata[255-8i -: 8]; char 0 is top-left.
- update, input, 1: single-cycle request to rewrite the frame.
- busy, output, 1: high in every state except IDLE.
- lcd_e, output, 1: LCD enable strobe.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: tied 0 (write-only).
- lcd_dat, output, 4: LCD data nibble.

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, busy=1. State goes to PWRUP; pending flag and char index are cleared.
- One delay counter (20 bits) serves all waits. A wait of N cycles means exactly N clk cycles.
- Nibble transfer:
  - lcd_rs and lcd_dat are set up 1 cycle before lcd_e rises.
  - lcd_e stays high for E_CYC cycles, then goes low.
  - lcd_rs and lcd_dat are held stable for 1 cycle after lcd_e falls.
- Byte transfer:
  - High nibble first, then NIB_GAP_CYC cycles with lcd_e low, then the low nibble.
  - Then CMD_CYC cycles, or CLR_CYC cycles when the byte is command 0x01.
- States, in order:
  - PWRUP: wait PWRUP_CYC.
  - INIT1: nibble 0x3, wait INIT_CYC.
  - INIT2: nibble 0x3, wait CMD_CYC.
  - INIT3: nibble 0x3, wait CMD_CYC.
  - INIT4: nibble 0x2, wait CMD_CYC.
  - CFG: command bytes 0x28, 0x06, 0x0C, 0x01, in that order.
  - SNAP: copy strdata into an internal frame register (1 cycle).
  - ADDR1: command 0x80.
  - LINE1: data chars 0–15.
  - ADDR2: command 0xC0.
  - LINE2: data chars 16–31.
  - IDLE.
- IDLE: busy=0 and lcd_e=0. update=1 moves to SNAP on the next cycle. A pass is 34 bytes and does no init.
- Frame snapshot: only the snapshot taken in SNAP is displayed. Changes to strdata during a pass do not corrupt that pass.
- update while busy: sets a pending flag, and several requests collapse into one. When the pass or init finishes, a set pending flag goes straight to SNAP (no IDLE cycle) and the flag clears.
- rst mid-operation: on the next edge lcd_e=0 and the state is PWRUP. Full re-init follows, including the PWRUP wait.
- rst has priority over update in the same cycle.
- Character bytes are sent unmodified (no filtering).
- After reset, exactly 80 lcd_e pulses occur before busy first falls:
  - 4 init nibbles,
  - 4 config bytes × 2 nibbles,
  - 34 pass bytes × 2 nibbles.

Optional Feature:
- Macro: LCD_AUTOREFRESH_EN.
- Defined: in IDLE, strdata != frame register is treated exactly like an update pulse, so the display tracks the input automatically. An update pulse is still honoured.
- Not defined: rewrites happen only on update pulses and reset; the comparator is not built.

Test Plan (small timing parameters for sim: PWRUP_CYC=100, INIT_CYC=40, E_CYC=2, NIB_GAP_CYC=2, CMD_CYC=5, CLR_CYC=20):
- Reset, then free-run: the lcd_e rising-edge sequence carries exactly these 80 nibbles: 3,3,3,2,2,8,0,6,0,C,0,1,8,0, then char nibbles, C,0, then char nibbles. busy falls after the 80th; lcd_rw=0 throughout.
- strdata = "R00:000 00000000FD00|E00|M00|W00": data nibbles (rs=1) decode to these 32 ASCII bytes in order, with 0x80 before char 0 and 0xC0 before char 16.
- Timing: lcd_e high for exactly 2 cycles each pulse. lcd_dat and lcd_rs are stable from 1 cycle before the rise to 1 cycle after the fall. At least 20 cycles separate the 0x01 low nibble from the next nibble.
- In IDLE, pulse update with new strdata: busy rises the next cycle, exactly 68 pulses occur (no init nibbles), and the new text is written.
- During a pass, change strdata and pulse update 3 times: the current pass finishes with the old snapshot, then exactly one extra pass runs with the new data, then IDLE.
- Assert rst during LINE1 with lcd_e high: lcd_e=0 on the next cycle, no lcd_e pulse for 100 cycles, then the full 80-pulse sequence.
